ad9244_capture: RTL and testbench

- Single-clock capture buffer for the AD9244 14-bit ADC.
- Stores one 256-sample frame of ADC words and tracks over-range events.
- Computes a block mean over a programmable power-of-two window.
- Provides two independent readouts of the frozen frame:
  - an addressed serial readout for the host register path;
  - a 256-sample burst for the downstream FFT core.
- Sits between the ADC pins and the control/FFT logic.

---
 rtl/ad9244_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_ad9244_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9244_capture.sv
// AD9244 frame capture: 256-word buffer, block mean, serial and FFT readout.
// Define FFT_TWOS_COMP_EN to stream two's-complement samples to the FFT.
module ad9244_capture #(
  parameter int DW = 14,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WriteEn,
  input  logic          ReadEn,
  input  logic          start_FFT,
  input  logic [DW-1:0] Data_I,
  input  logic          OTR,
  input  logic [15:0]   ADCR_Length,
  input  logic [7:0]    ADCM_Length,
  input  logic          R_Restart_ADC,
  output logic [DW-1:0] Data_O_Serial,
  output logic [AW-1:0] AddrR_O,
  output logic          rdy_W,
  output logic          rdy_R,
  output logic          Sample_256,
  output logic [DW-1:0] Mean_ADC,
  output logic [DW-1:0] FFT_xn_re,
  output logic [1:0]    flag_OverFlow
);

  localparam int DEPTH = 1 << AW;
  localparam int ACCW  = DW + AW;

  typedef enum logic {
    W_FILL,
    W_FULL
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RUN,
    R_DONE
  } r_state_t;

  typedef enum logic {
    F_IDLE,
    F_RUN
  } f_state_t;

  w_state_t w_state;
  r_state_t r_state;
  f_state_t f_state;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_cnt;
  logic [AW-1:0]   rd_last;
  logic [AW-1:0]   f_addr;
  logic [ACCW-1:0] acc;
  logic [3:0]      win_sh_q;

  logic            wr_en;
  logic [3:0]      win_sh_in;
  logic [3:0]      win_sh;
  logic [AW:0]     win_last;
  logic            in_win;
  logic            win_hit;
  logic [ACCW-1:0] acc_sum;
  logic [1:0]      ovr_set;
  logic [AW-1:0]   rd_len_m1;
  logic [DW-1:0]   ser_raw;
  logic [DW-1:0]   fft_raw;
  logic [DW-1:0]   fft_word;

  // floor(log2(len)); zero selects the full frame
  function automatic logic [3:0] win_shift(input logic [7:0] len);
    logic [3:0] sh;
    sh = 4'(AW);
    for (int i = 0; i < 8; i++) begin
      if (len[i]) sh = 4'(i);
    end
    return sh;
  endfunction

  assign wr_en     = (w_state == W_FILL) && WriteEn;
  assign win_sh_in = win_shift(ADCM_Length);
  assign win_sh    = (wr_addr == '0) ? win_sh_in : win_sh_q;
  assign win_last  = ((AW+1)'(1) << win_sh) - (AW+1)'(1);
  assign in_win    = {1'b0, wr_addr} <= win_last;
  assign win_hit   = {1'b0, wr_addr} == win_last;
  assign acc_sum   = ((wr_addr == '0) ? '0 : acc)
                   + ACCW'(Data_I);

  always_comb begin
    ovr_set = 2'b11;
    if (Data_I == '1) ovr_set = 2'b10;
    else if (Data_I == '0) ovr_set = 2'b01;
  end

  always_comb begin
    rd_len_m1 = ADCR_Length[AW-1:0]
              - {{(AW-1){1'b0}}, 1'b1};
    if (ADCR_Length == '0 || ADCR_Length > 16'(DEPTH))
      rd_len_m1 = '1;
  end

  assign ser_raw = mem[rd_addr];
  assign fft_raw = mem[f_addr];

`ifdef FFT_TWOS_COMP_EN
  assign fft_word = {~fft_raw[DW-1], fft_raw[DW-2:0]};
`else
  assign fft_word = fft_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && !R_Restart_ADC && wr_en)
      mem[wr_addr] <= Data_I;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_FILL;
      wr_addr       <= '0;
      rdy_W         <= 1'b0;
      Sample_256    <= 1'b0;
      flag_OverFlow <= 2'b00;
      acc           <= '0;
      win_sh_q      <= '0;
      Mean_ADC      <= '0;
    end else if (R_Restart_ADC) begin
      w_state       <= W_FILL;
      wr_addr       <= '0;
      rdy_W         <= 1'b0;
      Sample_256    <= 1'b0;
      flag_OverFlow <= 2'b00;
      acc           <= '0;
    end else begin
      Sample_256 <= 1'b0;
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        if (wr_addr == '0) win_sh_q <= win_sh_in;
        if (in_win) acc <= acc_sum;
        if (win_hit) Mean_ADC <= DW'(acc_sum >> win_sh);
        if (OTR) flag_OverFlow <= flag_OverFlow | ovr_set;
        if (wr_addr == '1) begin
          w_state    <= W_FULL;
          rdy_W      <= 1'b1;
          Sample_256 <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      rd_addr       <= '0;
      rd_cnt        <= '0;
      rd_last       <= '0;
      Data_O_Serial <= '0;
      AddrR_O       <= '0;
      rdy_R         <= 1'b0;
    end else if (R_Restart_ADC) begin
      r_state <= R_IDLE;
      rdy_R   <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ReadEn && rdy_W) begin
            r_state <= R_RUN;
            rd_addr <= '0;
            rd_cnt  <= '0;
            rd_last <= rd_len_m1;
          end
        end
        R_RUN: begin
          if (ReadEn) begin
            Data_O_Serial <= ser_raw;
            AddrR_O       <= rd_addr;
            rd_addr       <= rd_addr + 1'b1;
            rd_cnt        <= rd_cnt + 1'b1;
            if (rd_cnt == rd_last) begin
              r_state <= R_DONE;
              rdy_R   <= 1'b1;
            end
          end
        end
        R_DONE: begin
          if (!ReadEn) begin
            r_state <= R_IDLE;
            rdy_R   <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_state   <= F_IDLE;
      f_addr    <= '0;
      FFT_xn_re <= '0;
    end else if (R_Restart_ADC) begin
      f_state <= F_IDLE;
    end else begin
      unique case (f_state)
        F_IDLE: begin
          if (start_FFT && rdy_W) begin
            f_state <= F_RUN;
            f_addr  <= '0;
          end
        end
        F_RUN: begin
          FFT_xn_re <= fft_word;
          f_addr    <= f_addr + 1'b1;
          if (f_addr == '1) f_state <= F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9244_capture.sv
// Scoreboard bench for ad9244_capture: directed frames, stream monitors.
// Honors FFT_TWOS_COMP_EN when building the expected FFT words.
module tb_ad9244_capture;

  localparam int DW = 14;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          WriteEn;
  logic          ReadEn;
  logic          start_FFT;
  logic [DW-1:0] Data_I;
  logic          OTR;
  logic [15:0]   ADCR_Length;
  logic [7:0]    ADCM_Length;
  logic          R_Restart_ADC;
  logic [DW-1:0] Data_O_Serial;
  logic [AW-1:0] AddrR_O;
  logic          rdy_W;
  logic          rdy_R;
  logic          Sample_256;
  logic [DW-1:0] Mean_ADC;
  logic [DW-1:0] FFT_xn_re;
  logic [1:0]    flag_OverFlow;

  always #5 clk = ~clk;

  ad9244_capture #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .WriteEn       (WriteEn),
    .ReadEn        (ReadEn),
    .start_FFT     (start_FFT),
    .Data_I        (Data_I),
    .OTR           (OTR),
    .ADCR_Length   (ADCR_Length),
    .ADCM_Length   (ADCM_Length),
    .R_Restart_ADC (R_Restart_ADC),
    .Data_O_Serial (Data_O_Serial),
    .AddrR_O       (AddrR_O),
    .rdy_W         (rdy_W),
    .rdy_R         (rdy_R),
    .Sample_256    (Sample_256),
    .Mean_ADC      (Mean_ADC),
    .FFT_xn_re     (FFT_xn_re),
    .flag_OverFlow (flag_OverFlow)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          r;
  } ser_t;

  ser_t          ser_q[$];
  logic [DW-1:0] fft_q[$];
  logic          ser_en = 1'b0;
  logic          fft_en = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            s256_cnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] s);
`ifdef FFT_TWOS_COMP_EN
    return {~s[DW-1], s[DW-2:0]};
`else
    return s;
`endif
  endfunction

  // monitor: pops expected words whenever a stream is live
  always @(negedge clk) begin
    ser_t          e;
    logic [DW-1:0] f;
    if (Sample_256) s256_cnt++;
    if (ser_en && ser_q.size() > 0) begin
      e = ser_q.pop_front();
      check("ser_addr", 32'(AddrR_O), 32'(e.a));
      check("ser_data", 32'(Data_O_Serial), 32'(e.d));
      check("ser_rdy", 32'(rdy_R), 32'(e.r));
    end
    if (fft_en && fft_q.size() > 0) begin
      f = fft_q.pop_front();
      check("fft_data", 32'(FFT_xn_re), 32'(f));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic o);
    WriteEn = 1'b1;
    Data_I  = d;
    OTR     = o;
    tick();
    WriteEn = 1'b0;
    OTR     = 1'b0;
  endtask

  task automatic ramp(input int base);
    for (int i = 0; i < 256; i++) wr(DW'(base + i), 1'b0);
  endtask

  task automatic restart;
    R_Restart_ADC = 1'b1;
    tick();
    R_Restart_ADC = 1'b0;
  endtask

  task automatic ser_read(input logic [15:0] len, input int n,
                          input int base, input int last);
    ser_t e;
    for (int i = 0; i < n; i++) begin
      e.a = AW'(i);
      e.d = DW'(base + i);
      e.r = (i == last);
      ser_q.push_back(e);
    end
    ADCR_Length = len;
    ReadEn      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    ser_en = 1'b1;
    for (int g = 0; g < 2000 && ser_q.size() > 0; g++)
      @(negedge clk);
    if (ser_q.size() > 0) begin
      check("ser_timeout", 32'(ser_q.size()), 32'd0);
      ser_q.delete();
    end
    ser_en = 1'b0;
    tick();
  endtask

  task automatic fft_burst(input int base);
    for (int i = 0; i < 256; i++) fft_q.push_back(fmt(DW'(base + i)));
    start_FFT = 1'b1;
    @(posedge clk);
    #1;
    start_FFT = 1'b0;
    @(posedge clk);
    fft_en = 1'b1;
    for (int g = 0; g < 2000 && fft_q.size() > 0; g++)
      @(negedge clk);
    if (fft_q.size() > 0) begin
      check("fft_timeout", 32'(fft_q.size()), 32'd0);
      fft_q.delete();
    end
    fft_en = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ser"}, 32'(Data_O_Serial), 32'd0);
    check({tag, "_addr"}, 32'(AddrR_O), 32'd0);
    check({tag, "_rdyw"}, 32'(rdy_W), 32'd0);
    check({tag, "_rdyr"}, 32'(rdy_R), 32'd0);
    check({tag, "_s256"}, 32'(Sample_256), 32'd0);
    check({tag, "_mean"}, 32'(Mean_ADC), 32'd0);
    check({tag, "_fft"}, 32'(FFT_xn_re), 32'd0);
    check({tag, "_flag"}, 32'(flag_OverFlow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    WriteEn = 1'b0;
    ReadEn = 1'b0;
    start_FFT = 1'b0;
    Data_I = '0;
    OTR = 1'b0;
    ADCR_Length = '0;
    ADCM_Length = '0;
    R_Restart_ADC = 1'b0;
    repeat (3) tick();
    check_zero("reset");

    // frame 1: ramp, mean over 128
    rst_n = 1'b1;
    ADCM_Length = 8'd128;
    ramp(0);
    check("s256_pulse", 32'(Sample_256), 32'd1);
    check("rdyw_full", 32'(rdy_W), 32'd1);
    tick();
    check("s256_low", 32'(Sample_256), 32'd0);
    check("s256_cnt1", 32'(s256_cnt), 32'd1);
    check("mean_128", 32'(Mean_ADC), 32'd63);
    for (int i = 0; i < 4; i++) wr(DW'(300), 1'b0);
    check("rdyw_hold", 32'(rdy_W), 32'd1);
    check("s256_cnt1b", 32'(s256_cnt), 32'd1);

    ser_read(16'd128, 128, 0, 127);
    check("rdyr_done", 32'(rdy_R), 32'd1);
    ReadEn = 1'b0;
    tick();
    check("rdyr_clr", 32'(rdy_R), 32'd0);
    check("ser_hold_a", 32'(AddrR_O), 32'd127);
    check("ser_hold_d", 32'(Data_O_Serial), 32'd127);

    fft_burst(0);

    // frame 2: restart, ignored FFT request, full window
    restart();
    check("rst2_rdyw", 32'(rdy_W), 32'd0);
    check("rst2_flag", 32'(flag_OverFlow), 32'd0);
    check("rst2_mean", 32'(Mean_ADC), 32'd63);
    start_FFT = 1'b1;
    tick();
    start_FFT = 1'b0;
    repeat (3) tick();
    check("fft_ignored", 32'(FFT_xn_re), 32'(fmt(DW'(255))));
    ADCM_Length = 8'd0;
    ramp(0);
    check("mean_256", 32'(Mean_ADC), 32'd127);
    tick();
    check("s256_cnt2", 32'(s256_cnt), 32'd2);

    // frame 3: window 200 -> 128, over-range events
    restart();
    ADCM_Length = 8'd200;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) begin
        wr(14'h3FFF, 1'b1);
        check("ovr_pos", 32'(flag_OverFlow), 32'd2);
      end else if (i == 20) begin
        wr(14'h0000, 1'b1);
        check("ovr_both", 32'(flag_OverFlow), 32'd3);
      end else begin
        wr(DW'(i), 1'b0);
      end
    end
    check("mean_200", 32'(Mean_ADC), 32'd191);
    check("ovr_sticky", 32'(flag_OverFlow), 32'd3);
    restart();
    check("rst3_flag", 32'(flag_OverFlow), 32'd0);
    check("rst3_rdyw", 32'(rdy_W), 32'd0);

    // frame 4: restart at write index 100
    ADCM_Length = 8'd64;
    for (int i = 0; i < 100; i++) wr(DW'(500 + i), 1'b0);
    check("mean_64", 32'(Mean_ADC), 32'd531);
    WriteEn = 1'b1;
    Data_I = DW'(777);
    restart();
    WriteEn = 1'b0;
    check("rst4_rdyw", 32'(rdy_W), 32'd0);
    ADCM_Length = 8'd1;
    ramp(1000);
    check("mean_1", 32'(Mean_ADC), 32'd1000);
    check("rdyw_f4", 32'(rdy_W), 32'd1);
    fft_burst(1000);

    // reset in the middle of a 256-word readout
    ser_read(16'd300, 40, 1000, -1);
    rst_n = 1'b0;
    tick();
    check_zero("midrst");
    rst_n = 1'b1;
    ReadEn = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
